// File: rtl/ycbcr_rgb_pkg.sv
// Shared constants and types for the BT.601 studio-range YCbCr to full-range RGB pipeline.
// Pure definitions; latency and backpressure live in the modules that import this.
package ycbcr_rgb_pkg;

  localparam int LATENCY = 3;

  typedef logic signed [19:0] prod_t;
  typedef logic signed [21:0] sum_t;

  localparam logic signed [8:0] Y_OFS = 9'sd16;
  localparam logic signed [8:0] C_OFS = 9'sd128;

  localparam prod_t K_Y  = 20'sd298;
  localparam prod_t K_RV = 20'sd409;
  localparam prod_t K_GU = 20'sd100;
  localparam prod_t K_GV = 20'sd208;
  localparam prod_t K_BU = 20'sd516;
  localparam sum_t  RND  = 22'sd128;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } pix_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic bypass;
  } sync_t;

  // Returns {clipped, value}; the sum has already been rounded and shifted.
  function automatic logic [8:0] clamp8(input sum_t s);
    if (s < 22'sd0) begin
      return 9'h100;
    end else if (s > 22'sd255) begin
      return 9'h1FF;
    end else begin
      return {1'b0, s[7:0]};
    end
  endfunction

endpackage

// File: rtl/ycbcr2rgb_pipe_if.sv
// Video bus of the colour converter: sync/enable/pixel in, RGB plus per-frame clip stats out.
// master = video source and sink side, slave = the converter.
interface ycbcr2rgb_pipe_if #(
  parameter int CNT_W = 24
);
  logic             hs_in;
  logic             vs_in;
  logic             de_in;
  logic [7:0]       y_in;
  logic [7:0]       cb_in;
  logic [7:0]       cr_in;
  logic             bypass;
  logic             hs_out;
  logic             vs_out;
  logic             de_out;
  logic [7:0]       r_out;
  logic [7:0]       g_out;
  logic [7:0]       b_out;
  logic [CNT_W-1:0] clip_cnt;
  logic             clip_vld;

  modport master (
    output hs_in, vs_in, de_in, y_in, cb_in, cr_in, bypass,
    input  hs_out, vs_out, de_out, r_out, g_out, b_out, clip_cnt, clip_vld
  );

  modport slave (
    input  hs_in, vs_in, de_in, y_in, cb_in, cr_in, bypass,
    output hs_out, vs_out, de_out, r_out, g_out, b_out, clip_cnt, clip_vld
  );
endinterface

// File: rtl/sync_delay.sv
// Fixed-depth register delay line for sync/control bits; latency DEPTH cycles.
// Free-running, no backpressure.
module sync_delay #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];
endmodule

// File: rtl/ycbcr2rgb_pipe.sv
// BT.601 YCbCr 4:4:4 to full-range RGB with clamp, bypass and per-frame clip counter.
// Latency 3 cycles (multiply / sum+round / clamp), one pixel per cycle, no backpressure.
module ycbcr2rgb_pipe
  import ycbcr_rgb_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input logic             clk,
  input logic             rst_n,
  ycbcr2rgb_pipe_if.slave vid
);
  logic signed [8:0] y_ofs, cb_ofs, cr_ofs;
  pix_t              pix_s1, pix_s2, pix_s3;
  prod_t             p_y, p_rv, p_gu, p_gv, p_bu;
  sum_t              r_s2, g_s2, b_s2;
  logic [8:0]        r_cl, g_cl, b_cl;
  logic [7:0]        r_s3, g_s3, b_s3;
  logic              clip_s3;
  sync_t             sync_d;

  logic [CNT_W-1:0]  run_cnt, clip_cnt_q, frame_total;
  logic              vs_prev, vs_rise, clip_hit;

  assign y_ofs  = $signed({1'b0, vid.y_in})  - Y_OFS;
  assign cb_ofs = $signed({1'b0, vid.cb_in}) - C_OFS;
  assign cr_ofs = $signed({1'b0, vid.cr_in}) - C_OFS;

  // S1: offset removal and coefficient products; raw pixel rides along for bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_s1 <= '0;
      p_y    <= '0;
      p_rv   <= '0;
      p_gu   <= '0;
      p_gv   <= '0;
      p_bu   <= '0;
    end else begin
      pix_s1 <= {vid.y_in, vid.cb_in, vid.cr_in};
      p_y    <= K_Y  * prod_t'(y_ofs);
      p_rv   <= K_RV * prod_t'(cr_ofs);
      p_gu   <= K_GU * prod_t'(cb_ofs);
      p_gv   <= K_GV * prod_t'(cr_ofs);
      p_bu   <= K_BU * prod_t'(cb_ofs);
    end
  end

  // S2: channel sums, rounding, arithmetic shift (floor).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_s2 <= '0;
      r_s2   <= '0;
      g_s2   <= '0;
      b_s2   <= '0;
    end else begin
      pix_s2 <= pix_s1;
      r_s2   <= (sum_t'(p_y) + sum_t'(p_rv) + RND) >>> 8;
      g_s2   <= (sum_t'(p_y) - sum_t'(p_gu) - sum_t'(p_gv) + RND) >>> 8;
      b_s2   <= (sum_t'(p_y) + sum_t'(p_bu) + RND) >>> 8;
    end
  end

  assign r_cl = clamp8(r_s2);
  assign g_cl = clamp8(g_s2);
  assign b_cl = clamp8(b_s2);

  // S3: clamp into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_s3  <= '0;
      r_s3    <= '0;
      g_s3    <= '0;
      b_s3    <= '0;
      clip_s3 <= 1'b0;
    end else begin
      pix_s3  <= pix_s2;
      r_s3    <= r_cl[7:0];
      g_s3    <= g_cl[7:0];
      b_s3    <= b_cl[7:0];
      clip_s3 <= r_cl[8] | g_cl[8] | b_cl[8];
    end
  end

  sync_delay #(
    .WIDTH($bits(sync_t)),
    .DEPTH(LATENCY)
  ) u_sync_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({vid.hs_in, vid.vs_in, vid.de_in, vid.bypass}),
    .q    (sync_d)
  );

  assign vid.hs_out = sync_d.hs;
  assign vid.vs_out = sync_d.vs;
  assign vid.de_out = sync_d.de;
  assign vid.r_out  = !sync_d.de ? 8'd0 : (sync_d.bypass ? pix_s3.y  : r_s3);
  assign vid.g_out  = !sync_d.de ? 8'd0 : (sync_d.bypass ? pix_s3.cb : g_s3);
  assign vid.b_out  = !sync_d.de ? 8'd0 : (sync_d.bypass ? pix_s3.cr : b_s3);

  // A clipped pixel landing on the vs_out rise still belongs to the closing frame.
  assign clip_hit = sync_d.de & ~sync_d.bypass & clip_s3;
  assign vs_rise  = sync_d.vs & ~vs_prev;

  always_comb begin
    frame_total = run_cnt;
    if (clip_hit && run_cnt != {CNT_W{1'b1}}) begin
      frame_total = run_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev    <= 1'b0;
      run_cnt    <= '0;
      clip_cnt_q <= '0;
    end else begin
      vs_prev <= sync_d.vs;
      if (vs_rise) begin
        run_cnt    <= '0;
        clip_cnt_q <= frame_total;
      end else begin
        run_cnt <= frame_total;
      end
    end
  end

  assign vid.clip_vld = vs_rise;
  assign vid.clip_cnt = vs_rise ? frame_total : clip_cnt_q;
endmodule
